// File: rtl/vip_featuremap_collector.sv
// Pops one pixel from every per-filter FIFO together and serialises the channels
// (ch0..chN-1) into one tagged stream, stopping with a sticky done after num_data pixels.
module vip_featuremap_collector #(
    parameter int DWIDTH = 32,
    parameter int NUM_CH = 8,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [31:0]              num_data,
    input  logic [NUM_CH*DWIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_empty,
    output logic [NUM_CH-1:0]        in_rdreq,
    output logic [DWIDTH-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic                     out_last,
    output logic                     out_wrreq,
    input  logic                     out_full,
    output logic [31:0]              pixel_count,
    output logic                     done
);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPTURE, S_SEND, S_DONE} state_t;

    localparam logic [CH_W-1:0] LAST_IDX = CH_W'(NUM_CH - 1);

    state_t                        state;
    logic [CH_W-1:0]               idx;
    logic [NUM_CH-1:0][DWIDTH-1:0] hold;
    logic                          last_word;
    logic                          start_ok;

    assign last_word = (idx == LAST_IDX);
    // Any empty channel blocks the pop, so channels can never drift apart.
    assign start_ok  = (in_empty == '0) && (num_data != 32'd0) && (pixel_count < num_data);

    assign in_rdreq  = {NUM_CH{state == S_READ}};
    assign out_wrreq = (state == S_SEND) && !out_full;
    assign out_data  = hold[idx];
    assign out_ch    = idx;
    assign out_last  = (state == S_SEND) && last_word && (pixel_count == num_data - 32'd1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            hold        <= '0;
            pixel_count <= '0;
            done        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok)
                        state <= S_READ;
                end
                S_READ: begin
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    // FIFO q is valid one cycle after the pop.
                    hold  <= in_data;
                    idx   <= '0;
                    state <= S_SEND;
                end
                S_SEND: begin
                    if (!out_full) begin
                        if (!last_word) begin
                            idx <= idx + 1'b1;
                        end else begin
                            pixel_count <= pixel_count + 32'd1;
                            if (pixel_count + 32'd1 == num_data) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= S_IDLE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vip_featuremap_collector.sv
// Scoreboard bench: stimulus pushes expected words, forked monitors pop and compare
// whenever a DUT writes; an 8-channel and a 3-channel instance are exercised.
module tb_vip_featuremap_collector;

    typedef struct {
        logic [31:0] d;
        logic [2:0]  ch;
        logic        last;
    } exp_t;

    logic         clock = 1'b0;
    logic         rst, rst_s;
    logic [31:0]  num_data, num_data_s;
    logic [255:0] in_data;
    logic [47:0]  in_data_s;
    logic [7:0]   src_en, in_empty, in_rdreq;
    logic [2:0]   src_en_s, in_empty_s, in_rdreq_s;
    logic [31:0]  out_data;
    logic [15:0]  out_data_s;
    logic [2:0]   out_ch;
    logic [1:0]   out_ch_s;
    logic         out_last, out_wrreq, out_full, done;
    logic         out_last_s, out_wrreq_s, out_full_s, done_s;
    logic [31:0]  pixel_count, pixel_count_s;

    int   n_cmp = 0, n_err = 0;
    int   cyc = 0, last_wr_cyc = 0, wr_cnt = 0, rd_pulses = 0;
    int   cyc_s = 0, last_wr_cyc_s = 0, wr_cnt_s = 0;
    int   rdc[8], rdc_s[3];
    exp_t q[$], qs[$];
    int   c0q[$];

    always #5 clock = ~clock;

    assign in_empty   = ~src_en;
    assign in_empty_s = ~src_en_s;

    vip_featuremap_collector #(.DWIDTH(32), .NUM_CH(8)) dut (
        .clock(clock), .reset(rst), .num_data(num_data), .in_data(in_data),
        .in_empty(in_empty), .in_rdreq(in_rdreq), .out_data(out_data), .out_ch(out_ch),
        .out_last(out_last), .out_wrreq(out_wrreq), .out_full(out_full),
        .pixel_count(pixel_count), .done(done)
    );

    vip_featuremap_collector #(.DWIDTH(16), .NUM_CH(3)) dut_s (
        .clock(clock), .reset(rst_s), .num_data(num_data_s), .in_data(in_data_s),
        .in_empty(in_empty_s), .in_rdreq(in_rdreq_s), .out_data(out_data_s), .out_ch(out_ch_s),
        .out_last(out_last_s), .out_wrreq(out_wrreq_s), .out_full(out_full_s),
        .pixel_count(pixel_count_s), .done(done_s)
    );

    // Non-show-ahead source FIFOs: channel c pixel p = c*256+p, restarted by reset.
    always @(posedge clock) begin
        for (int c = 0; c < 8; c++) begin
            if (rst) rdc[c] <= 0;
            else if (in_rdreq[c]) begin
                in_data[c*32 +: 32] <= 32'(c*256 + rdc[c]);
                rdc[c] <= rdc[c] + 1;
            end
        end
    end

    always @(posedge clock) begin
        for (int c = 0; c < 3; c++) begin
            if (rst_s) rdc_s[c] <= 0;
            else if (in_rdreq_s[c]) begin
                in_data_s[c*16 +: 16] <= 16'(c*256 + rdc_s[c]);
                rdc_s[c] <= rdc_s[c] + 1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input int n);
        for (int p = 0; p < n; p++)
            for (int c = 0; c < 8; c++)
                q.push_back('{d: 32'(c*256 + p), ch: 3'(c), last: (p == n-1 && c == 7)});
    endtask

    task automatic mon_main();
        exp_t e;
        logic prev_rd = 1'b0;
        forever begin
            @(negedge clock);
            cyc++;
            if (rst) begin
                prev_rd = 1'b0;
            end else begin
                if (out_wrreq) begin
                    wr_cnt++;
                    last_wr_cyc = cyc;
                    if (q.size() == 0) check("wr_unexpected", 64'(out_wrreq), 64'd0);
                    else begin
                        e = q.pop_front();
                        check("word", {23'd0, out_last, 5'd0, out_ch, out_data},
                              {23'd0, e.last, 5'd0, e.ch, e.d});
                    end
                end
                if (in_rdreq != 8'h00) begin
                    rd_pulses++;
                    check("rdreq_pulse", 64'({in_rdreq, in_empty, 7'd0, prev_rd}),
                          64'({8'hFF, 8'h00, 8'h00}));
                end
                prev_rd = (in_rdreq != 8'h00);
            end
        end
    endtask

    task automatic mon_small();
        exp_t e;
        forever begin
            @(negedge clock);
            cyc_s++;
            if (!rst_s && out_wrreq_s) begin
                wr_cnt_s++;
                last_wr_cyc_s = cyc_s;
                if (out_ch_s == 2'd0) c0q.push_back(cyc_s);
                if (qs.size() == 0) check("s_wr_unexpected", 64'(out_wrreq_s), 64'd0);
                else begin
                    e = qs.pop_front();
                    check("s_word", {23'd0, out_last_s, 6'd0, out_ch_s, 16'd0, out_data_s},
                          {23'd0, e.last, 6'd0, e.ch[1:0], 16'd0, e.d[15:0]});
                end
            end
            if (!rst_s && in_rdreq_s != 3'd0)
                check("s_rdreq", 64'({in_rdreq_s, in_empty_s}), 64'({3'b111, 3'b000}));
        end
    endtask

    task automatic wait_done(input int budget, input string name);
        int k = 0;
        while (!done && k < budget) begin
            @(negedge clock);
            k++;
        end
        #1;
        check({name, "_timeout"}, 64'(k < budget), 64'd1);
        check({name, "_done_lag"}, 64'(cyc - last_wr_cyc), 64'd1);
        check({name, "_queue_left"}, 64'(q.size()), 64'd0);
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_rdreq"}, 64'(in_rdreq), 64'd0);
        check({name, "_wrreq"}, 64'(out_wrreq), 64'd0);
        check({name, "_last"}, 64'(out_last), 64'd0);
        check({name, "_data"}, 64'(out_data), 64'd0);
        check({name, "_ch"}, 64'(out_ch), 64'd0);
        check({name, "_pixcnt"}, 64'(pixel_count), 64'd0);
        check({name, "_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        int k;
        rst = 1'b1; rst_s = 1'b1;
        num_data = 32'd4; num_data_s = 32'd3;
        src_en = 8'h00; src_en_s = 3'b000;
        out_full = 1'b0; out_full_s = 1'b0;
        fork
            mon_main();
            mon_small();
        join_none
        repeat (2) @(posedge clock);
        #1;
        check_reset_vals("reset");

        // Frame 1: free-running, 4 pixels.
        push_frame(4);
        src_en = 8'hFF;
        rd_pulses = 0; wr_cnt = 0;
        rst = 1'b0;
        wait_done(200, "f1");
        check("f1_pixcnt", 64'(pixel_count), 64'd4);
        check("f1_words", 64'(wr_cnt), 64'd32);
        check("f1_rd_pulses", 64'(rd_pulses), 64'd4);

        // Frame 2: out_full held 5 cycles with idx=3 on pixel 1.
        @(posedge clock); #1 rst = 1'b1;
        push_frame(4);
        wr_cnt = 0;
        @(posedge clock); #1 rst = 1'b0;
        k = 0;
        while (!(out_wrreq && out_ch == 3'd2 && pixel_count == 32'd1) && k < 300) begin
            @(negedge clock);
            k++;
        end
        check("f2_reach_stall", 64'(k < 300), 64'd1);
        @(posedge clock); #1 out_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("f2_stall_wrreq", 64'(out_wrreq), 64'd0);
            check("f2_stall_data", 64'(out_data), 64'd769);
            check("f2_stall_ch", 64'(out_ch), 64'd3);
        end
        @(posedge clock); #1 out_full = 1'b0;
        wait_done(300, "f2");
        check("f2_words", 64'(wr_cnt), 64'd32);

        // Frame 3: ch7 starved, then reset mid-SEND of pixel 2.
        @(posedge clock); #1 rst = 1'b1;
        src_en = 8'h7F;
        push_frame(4);
        @(posedge clock); #1 rst = 1'b0;
        rd_pulses = 0;
        repeat (20) begin
            @(negedge clock);
            check("f3_starved_rdreq", 64'(in_rdreq), 64'd0);
        end
        @(posedge clock); #1 src_en = 8'hFF;
        k = 0;
        while (in_rdreq == 8'h00 && k < 5) begin
            @(negedge clock);
            k++;
        end
        check("f3_rd_latency_ok", 64'(k <= 2), 64'd1);
        k = 0;
        while (!(out_wrreq && out_ch == 3'd5 && pixel_count == 32'd2) && k < 300) begin
            @(negedge clock);
            k++;
        end
        check("f3_reach_reset_point", 64'(k < 300), 64'd1);
        #1 rst = 1'b1;
        q.delete();
        #1 check_reset_vals("midreset");
        num_data = 32'd2;
        push_frame(2);
        wr_cnt = 0;
        @(posedge clock); #1 rst = 1'b0;
        wait_done(200, "f4");
        check("f4_words", 64'(wr_cnt), 64'd16);
        check("f4_pixcnt", 64'(pixel_count), 64'd2);

        // num_data = 0: collector must stay idle.
        @(posedge clock); #1 rst = 1'b1;
        num_data = 32'd0;
        @(posedge clock); #1 rst = 1'b0;
        rd_pulses = 0; wr_cnt = 0;
        repeat (50) @(negedge clock);
        #1;
        check("zero_rd_pulses", 64'(rd_pulses), 64'd0);
        check("zero_words", 64'(wr_cnt), 64'd0);
        check("zero_done", 64'(done), 64'd0);

        // 3-channel, 16-bit instance, 3 pixels.
        for (int p = 0; p < 3; p++)
            for (int c = 0; c < 3; c++)
                qs.push_back('{d: 32'(c*256 + p), ch: 3'(c), last: (p == 2 && c == 2)});
        src_en_s = 3'b111;
        @(posedge clock); #1 rst_s = 1'b0;
        k = 0;
        while (!done_s && k < 100) begin
            @(negedge clock);
            k++;
        end
        #1;
        check("s_timeout", 64'(k < 100), 64'd1);
        check("s_done_lag", 64'(cyc_s - last_wr_cyc_s), 64'd1);
        check("s_words", 64'(wr_cnt_s), 64'd9);
        check("s_pixcnt", 64'(pixel_count_s), 64'd3);
        check("s_queue_left", 64'(qs.size()), 64'd0);
        check("s_pixel_starts", 64'(c0q.size()), 64'd3);
        if (c0q.size() == 3) begin
            check("s_period_0_1", 64'(c0q[1] - c0q[0]), 64'd6);
            check("s_period_1_2", 64'(c0q[2] - c0q[1]), 64'd6);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vip_featuremap_collector.md
# vip_featuremap_collector

Parametrised output collector for a convolution layer's feature-map channels. It pops one pixel from each of NUM_CH per-filter output FIFOs in lockstep. It then serialises them channel-interleaved (pixel p: ch0..chN-1) into a single downstream FIFO with a channel tag and end-of-frame marker. It stops after num_data pixels per channel and raises a sticky done. It replaces per-filter writer fan-out behind a conv2d layer with one stream to memory or the next layer.

## Interface
- DWIDTH, 32, bits per feature-map word
- NUM_CH, 8, number of filter channels (≥1)
- CH_W, $clog2(NUM_CH) (min 1), channel tag width
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- num_data  in  32  pixels per channel in the frame; held stable while frame runs
- in_data  in  NUM_CH*DWIDTH  channel c at bits [c*DWIDTH +: DWIDTH]; non-show-ahead FIFO q
- in_empty  in  NUM_CH  per-channel FIFO empty
- in_rdreq  out  NUM_CH  per-channel FIFO read request (always all-equal)
- out_data  out  DWIDTH  serialised word
- out_ch  out  CH_W  channel index of out_data
- out_last  out  1  high on last word of last pixel
- out_wrreq  out  1  write strobe to downstream FIFO
- out_full  in  1  downstream FIFO full
- pixel_count  out  32  pixels fully emitted this frame
- done  out  1  sticky frame-complete flag

## Operation
- States: IDLE, READ, CAPTURE, SEND, DONE.
- IDLE: go to READ when in_empty == 0 (all channels non-empty) and num_data != 0 and pixel_count < num_data; else stay. num_data == 0: stay IDLE forever, no reads, done stays 0.
- READ (1 cycle): in_rdreq = all ones. Exactly one pop per channel.
- CAPTURE (1 cycle): latch every in_data slice into hold[0..NUM_CH-1]; idx ← 0.
- SEND: out_data = hold[idx], out_ch = idx, out_wrreq = !out_full. On each cycle with out_wrreq: if idx < NUM_CH-1, idx++. Otherwise pixel_count++, and next state is DONE when pixel_count+1 == num_data, else IDLE.
- out_last = (state==SEND) && idx==NUM_CH-1 && pixel_count==num_data-1.
- DONE: done = 1, no reads or writes; held until reset.
- Word order per pixel is strictly ch0..chNUM_CH-1. No word is dropped, duplicated or reordered under any out_full pattern.
- Partial channel availability never causes a read: either all channels pop or none.

## Timing
- Reset (async): state IDLE; in_rdreq 0, out_wrreq 0, out_last 0, out_data 0, out_ch 0, pixel_count 0, done 0, hold cleared.
- in_rdreq is registered-state decoded: high only in READ, never two consecutive cycles.
- Data is sampled in CAPTURE, the cycle after rdreq (non-show-ahead FIFO latency 1).
- out_wrreq is combinational from state and out_full: a word is transferred on any rising edge with out_wrreq=1.
- When out_full=1 in SEND: out_wrreq=0, and out_data/out_ch/out_last hold their values.
- Minimum per-pixel period: NUM_CH+3 cycles (IDLE check, READ, CAPTURE, NUM_CH SEND).
- done rises the cycle after the final write; pixel_count == num_data at that point.
- Reset asserted mid-frame (any state): immediate return to reset values. Words already popped from the input FIFOs are discarded and the frame restarts from pixel 0 with a fresh count.
- pixel_count is 32-bit and does not wrap in normal use (bounded by num_data).

## Test plan
- NUM_CH=8, DWIDTH=32, num_data=4; channel c pixel p = c*256+p; out_full=0. Expect 32 writes in order 0,256,…,1792,1,257,…; out_ch cycles 0..7; out_last only on word 31 (value 1795); pixel_count=4; done=1 one cycle later; exactly 4 rdreq pulses.
- Same stimulus with out_full held high for 5 cycles while idx=3. Expect out_wrreq=0 and out_data=768+p held for those cycles, then resumption at idx 3; full 32-word sequence is intact.
- Channels 0–6 non-empty, ch7 empty for 20 cycles. Expect in_rdreq=0 on all channels throughout; first READ within 2 cycles of ch7 going non-empty.
- Reset pulsed during SEND of pixel 2 (idx=5). Expect all outputs 0 and pixel_count 0 asynchronously. A subsequent frame with num_data=2 emits 16 words and sets done.
- NUM_CH=3, DWIDTH=16, num_data=3. Expect 9 words; out_ch sequence 0,1,2 repeated; out_last on word 9; per-pixel period 6 cycles with out_full=0.
- num_data=0 with all inputs non-empty for 50 cycles. Expect no rdreq, no wrreq, done=0.
